store_buffer: RTL and testbench
===============================

# store_buffer

Posted-store buffer between the execute stage and the data memory port. Stores are accepted into a DEPTH-entry FIFO and retired one per idle memory cycle. Loads issue to memory immediately unless they overlap a buffered store. A drain handshake supports fence and ebreak handling.

## Interface
- DEPTH, 4: number of store entries; power of two, 2..16.
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request from EXU.
- req_ready  out  1  request accepted this cycle when req_valid && req_ready.
- req_wen  in  1  1 = store, 0 = load.
- req_addr  in  64  byte address; misalignment allowed.
- req_memop  in  3  [1:0] size (3 = 1B, 2 = 2B, 1 = 4B, 0 = 8B), [2] = sign-extend on load.
- req_wdata  in  64  store data, right-aligned.
- resp_valid  out  1  load data valid; one-cycle pulse.
- resp_rdata  out  64  extended load data.
- mem_addr, mem_memop, mem_wdata, mem_wen  out  64/3/64/1  to data memory; combinational port.
- mem_rdata  in  64  data memory read result, same cycle, already extended.
- drain_req  in  1  level: request buffer empty.
- sb_empty  out  1  no entries valid.

## Operation
- Entry fields: addr[63:0], memop[2:0], wdata[63:0], plus a valid bit. Ring FIFO uses head/tail pointers and a count of $clog2(DEPTH)+1 bits.
- Byte range of an access is [addr, addr+n-1], where n = 1/2/4/8 from memop[1:0]. Range arithmetic is 64-bit and wraps modulo 2^64.
- **Load conflict:** the byte range intersects any valid entry's range.
- **req_ready:**
  - Store: count < DEPTH && !drain_req.
  - Load: no conflict && !drain_req.
- **Port arbitration each cycle:**
  1. An accepted load drives the mem port: mem_wen = 0, mem_memop = req_memop.
  2. Otherwise, if count > 0, the head entry drives the port with mem_wen = 1; head pops at the clock edge.
  3. Otherwise mem_memop = 3'd0, mem_wen = 0, other mem outputs 0.
- A store never drives the port in its acceptance cycle. It becomes visible to memory only via drain.
- **Simultaneous push and pop:** count unchanged, and both pointers advance.
- **Full:** the store stalls, and drain continues whenever no load is accepted. A pop with a push in the same cycle does not make a full buffer ready that cycle.
- **Conflicting load:** it stalls; drain proceeds each cycle until the overlapping entries retire, then the load is accepted.
- **drain_req:** blocks new acceptance; entries retire one per cycle; sb_empty rises combinationally when count == 0.
- **Reset:** count, pointers, valid bits, resp_valid = 0; resp_rdata = 0; sb_empty = 1. A reset mid-drain discards all entries; buffered stores are lost by design.

## Timing
- Store acceptance to memory write: minimum 1 cycle. The write occurs in the first cycle after acceptance with no accepted load.
- Load acceptance to resp_valid: exactly 1 cycle. resp_rdata is mem_rdata registered at the acceptance edge.
- resp_rdata holds its value until the next load response.
- Back-to-back loads: one per cycle, and they starve the drain. The EXU guarantees no indefinite load streams; no starvation counter.

## Configuration
- **STORE_BUFFER_FWD_EN** defined: a conflicting load forwards from the youngest matching entry, with no stall, when all of these hold:
  - addr equal to the load's addr,
  - memop[1:0] equal to the load's,
  - that youngest entry is the only overlapping one.
  
  Forwarded data is wdata truncated and extended per the load's memop[2], registered with the same 1-cycle latency. The mem port performs the drain that cycle instead of the load. Any other overlap stalls.
- **Undefined:** every conflict stalls as above.

## Structure
- Package sb_pkg:
  - memop size encodings;
  - function op_bytes(memop) returning 1..8;
  - function ext_data(data, memop) (sign/zero extension, same rules as data memory);
  - function range_overlap(a, an, b, bn);
  - typedef sb_entry_t.
- No sub-module. Overlap comparators are generated by a for-loop over entries.

## Test plan
- **Reset:** hold rst_n = 0 for 3 cycles → sb_empty = 1, resp_valid = 0, mem_memop = 0.
- **Store then non-overlapping load:**
  - Stimulus: store 8B 0x1122334455667788 @0x80001000, then load lw @0x80002000 the next cycle.
  - Response: load accepted with no stall and drives the port; resp_valid 1 cycle later; the store writes the following cycle.
- **Overlap stall:**
  - Stimulus: store sb 0xAB @0x80001003, then load lw (memop 3'b101) @0x80001000.
  - Response: req_ready = 0 for 1 cycle while the store drains; the load then returns 0xFFFFFFFF..AB-pattern per memory contents, sign-extended.
- **Full:**
  - Stimulus: 5 back-to-back stores with continuous loads blocking drain.
  - Response: 5th store stalls with count = 4; when loads stop it is accepted the cycle after the first pop.
- **Drain:** assert drain_req with 3 entries → 3 consecutive mem_wen cycles in FIFO order, sb_empty = 1 on cycle 3, req_ready = 0 throughout.
- **FWD_EN:**
  - Stimulus: store sh 0x8001 @0x100, then load lh (3'b110) @0x100.
  - Response: no stall; resp_rdata = 0xFFFFFFFFFFFF8001.

Source files
------------

// File: rtl/sb_pkg.sv
// Shared types and helpers for the posted-store buffer: memop size
// encodings, byte-count/extension helpers, wrap-around range overlap test.
package sb_pkg;

  typedef enum logic [1:0] {
    SZ_D = 2'd0,
    SZ_W = 2'd1,
    SZ_H = 2'd2,
    SZ_B = 2'd3
  } memop_size_e;

  localparam int unsigned ADDR_W = 64;
  localparam int unsigned DATA_W = 64;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [2:0]        memop;
    logic [DATA_W-1:0] wdata;
  } sb_entry_t;

  function automatic logic [3:0] op_bytes(input logic [2:0] memop);
    logic [3:0] n;
    case (memop_size_e'(memop[1:0]))
      SZ_B:    n = 4'd1;
      SZ_H:    n = 4'd2;
      SZ_W:    n = 4'd4;
      default: n = 4'd8;
    endcase
    return n;
  endfunction

  function automatic logic [DATA_W-1:0] ext_data(input logic [DATA_W-1:0] data,
                                                 input logic [2:0] memop);
    logic              sx;
    logic [DATA_W-1:0] r;
    sx = memop[2];
    case (memop_size_e'(memop[1:0]))
      SZ_B:    r = {{56{sx & data[7]}},  data[7:0]};
      SZ_H:    r = {{48{sx & data[15]}}, data[15:0]};
      SZ_W:    r = {{32{sx & data[31]}}, data[31:0]};
      default: r = data;
    endcase
    return r;
  endfunction

  // Circular intervals [a,a+an) and [b,b+bn) intersect iff either start
  // lies inside the other interval; modular differences handle 2^64 wrap.
  function automatic logic range_overlap(input logic [ADDR_W-1:0] a,
                                         input logic [3:0]        an,
                                         input logic [ADDR_W-1:0] b,
                                         input logic [3:0]        bn);
    logic [ADDR_W-1:0] d_ab;
    logic [ADDR_W-1:0] d_ba;
    d_ab = b - a;
    d_ba = a - b;
    return (d_ab < {60'd0, an}) || (d_ba < {60'd0, bn});
  endfunction

endpackage

// File: rtl/store_buffer.sv
// Posted-store buffer between EXU and the data memory port.
// Optional store-to-load forwarding: define STORE_BUFFER_FWD_EN.
module store_buffer
  import sb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [63:0] req_addr,
  input  logic [2:0]  req_memop,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic [63:0] mem_addr,
  output logic [2:0]  mem_memop,
  output logic [63:0] mem_wdata,
  output logic        mem_wen,
  input  logic [63:0] mem_rdata,
  input  logic        drain_req,
  output logic        sb_empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  sb_entry_t         ent [DEPTH];
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [CW-1:0]     count;
  logic [DEPTH-1:0]  ovl_vec;
  logic              conflict;
  logic              fwd_hit;
  logic [63:0]       fwd_data;
  logic              ld_acc;
  logic              ld_port;
  logic              push;
  logic              pop;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ovl
    assign ovl_vec[gi] = ent[gi].valid &&
                         range_overlap(req_addr, op_bytes(req_memop),
                                       ent[gi].addr, op_bytes(ent[gi].memop));
  end

  assign conflict = |ovl_vec;

`ifdef STORE_BUFFER_FWD_EN
  logic single_ovl;
  assign single_ovl = (ovl_vec != '0) && ((ovl_vec & (ovl_vec - 1'b1)) == '0);

  // With exactly one overlapping entry it is necessarily the youngest one.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (single_ovl && !req_wen && ovl_vec[i] &&
          ent[i].addr == req_addr && ent[i].memop[1:0] == req_memop[1:0]) begin
        fwd_hit  = 1'b1;
        fwd_data = ext_data(ent[i].wdata, req_memop);
      end
    end
  end
`else
  assign fwd_hit  = 1'b0;
  assign fwd_data = '0;
`endif

  assign req_ready = !drain_req &&
                     (req_wen ? (count < CW'(DEPTH)) : (!conflict || fwd_hit));
  assign ld_acc    = req_valid && !req_wen && req_ready;
  assign push      = req_valid &&  req_wen && req_ready;
  assign ld_port   = ld_acc && !fwd_hit;
  assign pop       = !ld_port && (count != '0);
  assign sb_empty  = (count == '0);

  always_comb begin
    mem_addr  = '0;
    mem_memop = '0;
    mem_wdata = '0;
    mem_wen   = 1'b0;
    if (ld_port) begin
      mem_addr  = req_addr;
      mem_memop = req_memop;
    end else if (pop) begin
      mem_addr  = ent[head].addr;
      mem_memop = ent[head].memop;
      mem_wdata = ent[head].wdata;
      mem_wen   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) ent[i] <= '0;
    end else begin
      if (pop) begin
        ent[head].valid <= 1'b0;
        head            <= head + 1'b1;
      end
      if (push) begin
        ent[tail] <= '{valid: 1'b1, addr: req_addr, memop: req_memop, wdata: req_wdata};
        tail      <= tail + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= 1'b0;
      resp_rdata <= '0;
    end else begin
      resp_valid <= ld_acc;
      if (ld_acc) resp_rdata <= fwd_hit ? fwd_data : mem_rdata;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Randomized self-checking bench for store_buffer against a byte-level
// architectural model (program-order memory plus pending-store queue).
module tb_store_buffer;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [63:0] req_addr;
  logic [2:0]  req_memop;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic [63:0] mem_addr;
  logic [2:0]  mem_memop;
  logic [63:0] mem_wdata;
  logic        mem_wen;
  logic [63:0] mem_rdata;
  logic        drain_req;
  logic        sb_empty;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_memop(req_memop), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .mem_addr(mem_addr), .mem_memop(mem_memop), .mem_wdata(mem_wdata),
    .mem_wen(mem_wen), .mem_rdata(mem_rdata),
    .drain_req(drain_req), .sb_empty(sb_empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    logic [2:0]  memop;
    logic [63:0] wdata;
  } st_t;

  st_t         sq[$];
  logic [7:0]  pmem [logic [63:0]];
  logic [7:0]  gold [logic [63:0]];
  int          mem_ver = 0;
  logic [63:0] last_rd;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  function automatic int nbytes(input logic [2:0] m);
    return 8 >> m[1:0];
  endfunction

  function automatic logic [7:0] dflt(input logic [63:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  function automatic logic [63:0] ext_ref(input logic [63:0] raw, input logic [2:0] m);
    int          n;
    logic [63:0] mask;
    logic [63:0] v;
    n    = nbytes(m);
    mask = (n == 8) ? '1 : ((64'd1 << (8 * n)) - 64'd1);
    v    = raw & mask;
    if (m[2] && n < 8 && raw[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [63:0] rd_p(input logic [63:0] a);
    logic [63:0] r;
    logic [63:0] k;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      k = a + 64'(i);
      r[8*i +: 8] = pmem.exists(k) ? pmem[k] : dflt(k);
    end
    return r;
  endfunction

  function automatic logic [63:0] rd_g(input logic [63:0] a);
    logic [63:0] r;
    logic [63:0] k;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      k = a + 64'(i);
      r[8*i +: 8] = gold.exists(k) ? gold[k] : dflt(k);
    end
    return r;
  endfunction

  function automatic bit bytes_overlap(input logic [63:0] a, input int na,
                                       input logic [63:0] b, input int nb);
    for (int i = 0; i < na; i++)
      for (int j = 0; j < nb; j++)
        if (a + 64'(i) == b + 64'(j)) return 1'b1;
    return 1'b0;
  endfunction

  // Data memory: combinational read, write on the clock edge.
  always @(mem_addr or mem_memop or mem_wen or mem_ver)
    mem_rdata = mem_wen ? '0 : ext_ref(rd_p(mem_addr), mem_memop);

  always @(posedge clk) begin
    if (rst_n && mem_wen) begin
      for (int i = 0; i < nbytes(mem_memop); i++) pmem[mem_addr + 64'(i)] = mem_wdata[8*i +: 8];
      mem_ver++;
    end
  end

  task automatic step(input bit v, input bit wen, input logic [63:0] a, input logic [2:0] m,
                      input logic [63:0] wd, input bit dr, output bit acc);
    int          novl;
    int          oidx;
    bit          fwd;
    bit          exp_ready;
    bit          port_ld;
    bit          popd;
    logic [63:0] exp_rd;
    @(negedge clk);
    req_valid = v; req_wen = wen; req_addr = a; req_memop = m; req_wdata = wd; drain_req = dr;
    #1;
    novl = 0;
    oidx = -1;
    fwd  = 1'b0;
    if (!wen)
      foreach (sq[i])
        if (bytes_overlap(a, nbytes(m), sq[i].addr, nbytes(sq[i].memop))) begin
          novl++;
          oidx = i;
        end
`ifdef STORE_BUFFER_FWD_EN
    if (novl == 1 && sq[oidx].addr == a && sq[oidx].memop[1:0] == m[1:0]) fwd = 1'b1;
`endif
    exp_ready = wen ? (sq.size() < DEPTH && !dr) : ((novl == 0 || fwd) && !dr);
    check("req_ready", 64'(req_ready), 64'(exp_ready));
    check("sb_empty", 64'(sb_empty), 64'(sq.size() == 0));
    acc     = v && exp_ready;
    port_ld = acc && !wen && !fwd;
    popd    = !port_ld && sq.size() > 0;
    exp_rd  = '0;
    if (port_ld) begin
      check("mem_wen_ld", 64'(mem_wen), 64'd0);
      check("mem_addr_ld", mem_addr, a);
      check("mem_memop_ld", 64'(mem_memop), 64'(m));
    end else if (popd) begin
      check("mem_wen_st", 64'(mem_wen), 64'd1);
      check("mem_addr_st", mem_addr, sq[0].addr);
      check("mem_memop_st", 64'(mem_memop), 64'(sq[0].memop));
      check("mem_wdata_st", mem_wdata, sq[0].wdata);
    end else begin
      check("mem_idle", {mem_wen, mem_memop, mem_addr[59:0]}, 64'd0);
      check("mem_idle_wd", mem_wdata, 64'd0);
    end
    if (acc && !wen) exp_rd = ext_ref(rd_g(a), m);
    @(posedge clk);
    if (popd) void'(sq.pop_front());
    if (acc && wen) begin
      sq.push_back('{addr: a, memop: m, wdata: wd});
      for (int i = 0; i < nbytes(m); i++) gold[a + 64'(i)] = wd[8*i +: 8];
    end
    #1;
    check("resp_valid", 64'(resp_valid), 64'(acc && !wen));
    if (acc && !wen) last_rd = exp_rd;
    check("resp_rdata", resp_rdata, last_rd);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 64'd0, 3'd0, 64'd0, 1'b0, acc);
  endtask

  task automatic load_wait(input logic [63:0] a, input logic [2:0] m, output int stalls);
    bit acc;
    stalls = 0;
    acc    = 1'b0;
    while (!acc && stalls < 20) begin
      step(1'b1, 1'b0, a, m, 64'd0, 1'b0, acc);
      if (!acc) stalls++;
    end
    check("load_bound", 64'(acc), 64'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req_valid = 1'b0; req_wen = 1'b0; req_addr = '0;
    req_memop = '0; req_wdata = '0; drain_req = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_sb_empty", 64'(sb_empty), 64'd1);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_mem_memop", 64'(mem_memop), 64'd0);
    check("rst_resp_rdata", resp_rdata, 64'd0);
    sq.delete();
    pmem.delete();
    gold.delete();
    mem_ver++;
    last_rd = '0;
    rst_n   = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit          acc;
    int          stalls;
    int          r;
    logic [63:0] a;
    logic [2:0]  m;
    do_reset();

    // store then non-overlapping load
    step(1'b1, 1'b1, 64'h80001000, 3'b000, 64'h1122334455667788, 1'b0, acc);
    check("t1_st_acc", 64'(acc), 64'd1);
    step(1'b1, 1'b0, 64'h80002000, 3'b101, 64'd0, 1'b0, acc);
    check("t1_ld_acc", 64'(acc), 64'd1);
    idle(2);

    // overlapping byte store stalls a word load for one drain cycle
    step(1'b1, 1'b1, 64'h80001003, 3'b011, 64'h00000000000000AB, 1'b0, acc);
    load_wait(64'h80001000, 3'b101, stalls);
    check("t2_stalls", 64'(stalls), 64'd1);
    check("t2_data", resp_rdata, 64'hFFFFFFFFAB667788);
    idle(1);

    // back-to-back stores, then drain request blocks acceptance
    for (int i = 0; i < 5; i++)
      step(1'b1, 1'b1, 64'h80001010 + 64'(8 * i), 3'b000, {$urandom, $urandom}, 1'b0, acc);
    step(1'b1, 1'b1, 64'h80001040, 3'b001, 64'h0BADF00D, 1'b1, acc);
    check("drain_blocks", 64'(acc), 64'd0);
    step(1'b0, 1'b0, 64'd0, 3'd0, 64'd0, 1'b1, acc);
    check("drain_empty", 64'(sb_empty), 64'd1);

    // overlap across the 2^64 wrap
    step(1'b1, 1'b1, 64'hFFFFFFFFFFFFFFFC, 3'b000, 64'hA1A2A3A4A5A6A7A8, 1'b0, acc);
    load_wait(64'h0000000000000002, 3'b011, stalls);
    check("wrap_stalls", 64'(stalls), 64'd1);
    check("wrap_data", resp_rdata, 64'h00000000000000A2);
    idle(1);

    // halfword store followed by same-address halfword load
    step(1'b1, 1'b1, 64'h100, 3'b010, 64'h8001, 1'b0, acc);
    load_wait(64'h100, 3'b110, stalls);
`ifdef STORE_BUFFER_FWD_EN
    check("fwd_stalls", 64'(stalls), 64'd0);
`else
    check("fwd_stalls", 64'(stalls), 64'd1);
`endif
    check("fwd_data", resp_rdata, 64'hFFFFFFFFFFFF8001);
    idle(1);

    // reset with a buffered store discards it
    step(1'b1, 1'b1, 64'h80003000, 3'b000, 64'hDEADBEEFDEADBEEF, 1'b0, acc);
    do_reset();

    for (int c = 0; c < 800; c++) begin
      r = $urandom_range(0, 9);
      a = 64'h80001000 + 64'($urandom_range(0, 23));
      m = 3'($urandom_range(0, 7));
      if (r < 4)       step(1'b1, 1'b1, a, m, {$urandom, $urandom}, 1'b0, acc);
      else if (r < 8)  step(1'b1, 1'b0, a, m, 64'd0, 1'b0, acc);
      else if (r == 8) step(1'b0, 1'b0, a, m, 64'd0, 1'b0, acc);
      else             step(1'b1, 1'(r & 1), a, m, {$urandom, $urandom}, 1'b1, acc);
    end
    idle(4);
    check("final_empty", 64'(sb_empty), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
